// File: rtl/if_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_stage_pkg : fetch-stage state encodings and shared constants    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package if_stage_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_stage_if : req/ack instruction-memory port                      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_skid_buf : one-entry {valid,inst,pc} holding register        |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_skid_buf (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        load,
  input  wire logic        take,
  input  wire logic        clear,
  input  wire logic [31:0] in_inst,
  input  wire logic [31:0] in_pc,
  output logic             valid,
  output logic [31:0]      inst,
  output logic [31:0]      pc
);

  // clear (flush) beats load, load beats take
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      inst  <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= in_inst;
      pc    <= in_pc;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_stage : RV32I instruction fetch, PC owner, IF/ID register       |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  wire logic        clk,
  input  wire logic        rst,
  if_stage_if.master       imem,
  input  wire logic        redirect_valid,
  input  wire logic [31:0] redirect_pc,
  input  wire logic        id_stall,
  output logic             if_id_valid,
  output logic [31:0]      if_id_inst,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc4
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n, tgt, tgt_n, rpc;
  logic         advance, ack_ok;
  logic         src_mem, src_skid, bubble;
  logic         skid_load, skid_take, skid_clear;
  logic         skid_valid;
  logic [31:0]  skid_inst, skid_pc;

  assign rpc      = redirect_pc & ~32'h3;
  assign advance  = !if_id_valid || !id_stall;
  assign imem.req  = !rst && (state != S_WAIT);
  assign imem.addr = pc;
  // acks outside an open request are ignored
  assign ack_ok   = imem.ack && (state != S_WAIT);

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .take    (skid_take),
    .clear   (skid_clear),
    .in_inst (imem.rdata),
    .in_pc   (pc),
    .valid   (skid_valid),
    .inst    (skid_inst),
    .pc      (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC & ~32'h3;
      tgt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      tgt   <= tgt_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    tgt_n      = tgt;
    src_mem    = 1'b0;
    src_skid   = 1'b0;
    bubble     = 1'b0;
    skid_load  = 1'b0;
    skid_take  = 1'b0;
    skid_clear = 1'b0;
    if (redirect_valid) begin
      bubble     = 1'b1;
      skid_clear = 1'b1;
      case (state)
        S_REQ: begin
          if (ack_ok) pc_n = rpc;
          else begin
            tgt_n   = rpc;
            state_n = S_DROP;
          end
        end
        S_WAIT: begin
          pc_n    = rpc;
          state_n = S_REQ;
        end
        S_DROP: begin
          tgt_n = rpc;
          if (ack_ok) begin
            pc_n    = rpc;
            state_n = S_REQ;
          end
        end
        default: state_n = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (ack_ok) begin
            pc_n = pc_plus4(pc);
            if (advance) src_mem = 1'b1;
            else begin
              skid_load = 1'b1;
              state_n   = S_WAIT;
            end
          end else if (advance) begin
            bubble = 1'b1;
          end
        end
        S_WAIT: begin
          if (advance) begin
            if (skid_valid) begin
              src_skid  = 1'b1;
              skid_take = 1'b1;
            end else begin
              bubble = 1'b1;
            end
            state_n = S_REQ;
          end
        end
        S_DROP: begin
          if (advance) bubble = 1'b1;
          if (ack_ok) begin
            pc_n    = tgt;
            state_n = S_REQ;
          end
        end
        default: state_n = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
    end else if (bubble) begin
      if_id_valid <= 1'b0;
      if_id_inst  <= NOP_INST;
    end else if (src_mem) begin
      if_id_valid <= 1'b1;
      if_id_inst  <= imem.rdata;
      if_id_pc    <= pc;
      if_id_pc4   <= pc_plus4(pc);
    end else if (src_skid) begin
      if_id_valid <= 1'b1;
      if_id_inst  <= skid_inst;
      if_id_pc    <= skid_pc;
      if_id_pc4   <= pc_plus4(skid_pc);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_if_stage : directed self-checking bench for if_stage            |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_id_valid;
  logic [31:0] if_id_inst, if_id_pc, if_id_pc4;
  int          n_checks = 0;
  int          n_fails  = 0;

  if_stage_if bus ();

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_id_valid    (if_id_valid),
    .if_id_inst     (if_id_inst),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic cyc(input logic ack, input logic stall, input logic rv, input logic [31:0] rp);
    bus.ack        = ack;
    bus.rdata      = ack ? inst_of(bus.addr) : 32'hDEAD_BEEF;
    id_stall       = stall;
    redirect_valid = rv;
    redirect_pc    = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic v, input logic [31:0] inst,
                      input logic [31:0] pc, input logic [31:0] pc4);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, ".inst"}, if_id_inst, inst);
    chk({tag, ".pc"}, if_id_pc, pc);
    chk({tag, ".pc4"}, if_id_pc4, pc4);
  endtask

  task automatic bus_is(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'd0, bus.req}, {31'd0, req});
    if (req) chk({tag, ".addr"}, bus.addr, addr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; bus.ack = 1'b0; bus.rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_stall = 1'b0;

    // reset values
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    bus_is("rst", 1'b0, 32'h0);
    ifid("rst", 1'b0, NOP, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    bus_is("first_req", 1'b1, 32'h0);

    // zero-wait streaming
    for (int k = 0; k < 4; k++) begin
      bus_is("stream", 1'b1, 32'(4 * k));
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      ifid("stream", 1'b1, inst_of(32'(4 * k)), 32'(4 * k), 32'(4 * k + 4));
    end
    bus_is("stream_end", 1'b1, 32'h10);

    // stall: i1 parks in the skid buffer
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    ifid("stall1", 1'b1, inst_of(32'h0), 32'h0, 32'h4);
    bus_is("stall1", 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    ifid("stall2", 1'b1, inst_of(32'h0), 32'h0, 32'h4);
    bus_is("stall2", 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    bus_is("stall3", 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    ifid("unstall", 1'b1, inst_of(32'h4), 32'h4, 32'h8);
    bus_is("unstall", 1'b1, 32'h8);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    ifid("resume", 1'b1, inst_of(32'h8), 32'h8, 32'hC);

    // wait states with redirect mid-request
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    bus_is("ws_pre", 1'b1, 32'h8);
    cyc(1'b0, 1'b0, 1'b1, 32'h100);
    bus_is("ws_drop1", 1'b1, 32'h8);
    chk("ws_drop1.valid", {31'd0, if_id_valid}, 32'd0);
    chk("ws_drop1.inst", if_id_inst, NOP);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    bus_is("ws_drop2", 1'b1, 32'h8);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    bus_is("ws_ack", 1'b1, 32'h100);
    chk("ws_ack.valid", {31'd0, if_id_valid}, 32'd0);
    chk("ws_ack.inst", if_id_inst, NOP);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    ifid("ws_tgt", 1'b1, inst_of(32'h100), 32'h100, 32'h104);

    // redirect with ack in the same cycle
    cyc(1'b1, 1'b0, 1'b1, 32'h200);
    bus_is("rd_ack", 1'b1, 32'h200);
    chk("rd_ack.valid", {31'd0, if_id_valid}, 32'd0);
    chk("rd_ack.inst", if_id_inst, NOP);
    // two redirects while the 0x200 request is outstanding
    cyc(1'b0, 1'b0, 1'b1, 32'h280);
    bus_is("drop_a", 1'b1, 32'h200);
    cyc(1'b0, 1'b0, 1'b1, 32'h300);
    bus_is("drop_b", 1'b1, 32'h200);
    chk("drop_b.valid", {31'd0, if_id_valid}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    bus_is("drop_ack", 1'b1, 32'h300);
    chk("drop_ack.inst", if_id_inst, NOP);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    ifid("drop_tgt", 1'b1, inst_of(32'h300), 32'h300, 32'h304);

    // flush overrides stall; wrap at top of address space
    cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
    bus_is("wrap_rd", 1'b1, 32'hFFFF_FFFC);
    chk("wrap_rd.valid", {31'd0, if_id_valid}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    ifid("wrap", 1'b1, inst_of(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0);
    bus_is("wrap", 1'b1, 32'h0);

    // reset while a request is pending
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    ifid("pre_rst", 1'b1, inst_of(32'h0), 32'h0, 32'h4);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    bus_is("pre_rst", 1'b1, 32'h4);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    bus_is("mid_rst", 1'b0, 32'h0);
    ifid("mid_rst", 1'b0, NOP, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    bus_is("post_rst", 1'b1, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    ifid("post_rst", 1'b1, inst_of(32'h0), 32'h0, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
